// File: rtl/float_to_int_pipe_if.sv
// Stream bundle for the float-to-int converter: input sample side and output result side.
interface float_to_int_pipe_if #(
  parameter int unsigned OUT_W = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [31:0]             floatin;
  logic                    round_mode;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] intout;
  logic                    ovf;
  logic                    invalid;
  logic                    underflow;

  // Producer/consumer side that feeds samples and drains results.
  modport master (
    output in_valid, floatin, round_mode, out_ready,
    input  in_ready, out_valid, intout, ovf, invalid, underflow
  );

  // Converter side.
  modport slave (
    input  in_valid, floatin, round_mode, out_ready,
    output in_ready, out_valid, intout, ovf, invalid, underflow
  );
endinterface

// File: rtl/float_to_int_pipe.sv
// Three-stage IEEE-754 single to signed fixed-point converter with rounding,
// saturation and per-sample NaN/overflow/underflow flags.
module float_to_int_pipe #(
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned FRAC_BITS = 0
) (
  input logic                 clk,
  input logic                 reset,
  float_to_int_pipe_if.slave  bus
);
  localparam int unsigned SH_W = 56;
  localparam int unsigned RW   = OUT_W + 1;
  localparam logic [OUT_W-1:0] HALF    = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] POS_MAX = ~HALF;

  logic adv_c;
  logic [7:0] e_c;
  logic signed [9:0] k_c;

  logic v1, s1_sign, s1_nan, s1_inf, s1_zero, s1_rm;
  logic [23:0] s1_mag;
  logic signed [9:0] s1_k;

  logic [47:0] ext_c;
  logic [9:0] nk_c;
  logic [SH_W-1:0] iw_c;
  logic guard_c, sticky_c, big_c, inc_c;
  logic [RW-1:0] rnd_c;

  logic v2, s2_sign, s2_big, s2_nan, s2_inf, s2_zero;
  logic [OUT_W-1:0] s2_mag;

  logic [OUT_W-1:0] res_c;
  logic ovf_c, inv_c, unf_c;

  logic out_valid_q, ovf_q, inv_q, unf_q;
  logic [OUT_W-1:0] intout_q;

  // Whole pipe moves together unless the output is held by the consumer.
  assign adv_c        = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv_c && reset;
  assign bus.out_valid = out_valid_q;
  assign bus.intout    = intout_q;
  assign bus.ovf       = ovf_q;
  assign bus.invalid   = inv_q;
  assign bus.underflow = unf_q;

  // Decode: shift amount that maps the 24-bit mantissa onto the fixed-point grid.
  assign e_c = bus.floatin[30:23];
  assign k_c = $signed({2'b00, e_c}) + $signed(10'(FRAC_BITS)) - 10'sd150;

  // Stage 1 register: split fields and classify.
  always_ff @(posedge clk) begin
    if (!reset) begin
      v1 <= 1'b0;
    end else if (adv_c) begin
      v1      <= bus.in_valid;
      s1_sign <= bus.floatin[31];
      s1_mag  <= {1'b1, bus.floatin[22:0]};
      s1_k    <= k_c;
      s1_nan  <= (e_c == 8'd255) && (bus.floatin[22:0] != 23'd0);
      s1_inf  <= (e_c == 8'd255) && (bus.floatin[22:0] == 23'd0);
      s1_zero <= (e_c == 8'd0);
      s1_rm   <= bus.round_mode;
    end
  end

  // Scale by barrel shift, keep guard/sticky, apply rounding increment.
  always_comb begin
    ext_c    = '0;
    nk_c     = '0;
    iw_c     = '0;
    guard_c  = 1'b0;
    sticky_c = 1'b0;
    big_c    = 1'b0;
    if (!s1_k[9]) begin
      if (s1_k > 10'sd32) big_c = 1'b1;
      else                iw_c  = SH_W'(s1_mag) << s1_k[5:0];
    end else begin
      nk_c = 10'(-s1_k);
      if (nk_c < 10'd25) ext_c = {s1_mag, 24'd0} >> nk_c[4:0];
      else               ext_c = 48'd1;
      iw_c     = SH_W'(ext_c[47:24]);
      guard_c  = ext_c[23];
      sticky_c = |ext_c[22:0];
    end
    big_c = big_c || (|iw_c[SH_W-1:OUT_W]);
    inc_c = s1_rm && guard_c && (sticky_c || iw_c[0]);
    rnd_c = {1'b0, iw_c[OUT_W-1:0]} + RW'(inc_c);
  end

  // Stage 2 register: rounded magnitude plus out-of-range marker.
  always_ff @(posedge clk) begin
    if (!reset) begin
      v2 <= 1'b0;
    end else if (adv_c) begin
      v2      <= v1;
      s2_sign <= s1_sign;
      s2_mag  <= rnd_c[OUT_W-1:0];
      s2_big  <= big_c || rnd_c[OUT_W];
      s2_nan  <= s1_nan;
      s2_inf  <= s1_inf;
      s2_zero <= s1_zero;
    end
  end

  // Apply sign and saturate to the output rails; derive flags.
  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    inv_c = 1'b0;
    unf_c = 1'b0;
    if (s2_nan) begin
      inv_c = 1'b1;
    end else if (s2_inf) begin
      ovf_c = 1'b1;
      res_c = s2_sign ? HALF : POS_MAX;
    end else if (!s2_zero) begin
      if (!s2_sign) begin
        if (s2_big || s2_mag > POS_MAX) begin
          res_c = POS_MAX;
          ovf_c = 1'b1;
        end else begin
          res_c = s2_mag;
        end
      end else begin
        if (s2_big || s2_mag > HALF) begin
          res_c = HALF;
          ovf_c = 1'b1;
        end else begin
          res_c = ~s2_mag + OUT_W'(1);
        end
      end
      unf_c = !s2_big && (s2_mag == '0);
    end
  end

  // Stage 3 register: the visible result, zeroed in bubble slots.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      intout_q    <= '0;
      ovf_q       <= 1'b0;
      inv_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else if (adv_c) begin
      out_valid_q <= v2;
      intout_q    <= v2 ? res_c : '0;
      ovf_q       <= v2 && ovf_c;
      inv_q       <= v2 && inv_c;
      unf_q       <= v2 && unf_c;
    end
  end
endmodule

// File: tb/tb_float_to_int_pipe.sv
// Directed bench: two converters (FRAC_BITS 0 and 8) checked against hand-computed vectors.
module tb_float_to_int_pipe;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  float_to_int_pipe_if #(.OUT_W(16)) b0 ();
  float_to_int_pipe_if #(.OUT_W(16)) b8 ();

  float_to_int_pipe #(.OUT_W(16), .FRAC_BITS(0)) u0 (.clk(clk), .reset(reset), .bus(b0));
  float_to_int_pipe #(.OUT_W(16), .FRAC_BITS(8)) u8 (.clk(clk), .reset(reset), .bus(b8));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] f;
    bit          rm;
    int          e0;
    int          fl0;
    int          e8;
    int          fl8;
  } vec_t;

  vec_t vt[$];

  // Flags packed as {ovf, invalid, underflow}.
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic add(input logic [31:0] f, input bit rm, input int e0, input int fl0,
                     input int e8, input int fl8);
    vec_t v;
    v.f = f; v.rm = rm; v.e0 = e0; v.fl0 = fl0; v.e8 = e8; v.fl8 = fl8;
    vt.push_back(v);
  endtask

  function automatic int flags0();
    return int'({b0.ovf, b0.invalid, b0.underflow});
  endfunction

  function automatic int flags8();
    return int'({b8.ovf, b8.invalid, b8.underflow});
  endfunction

  task automatic conv(input logic [31:0] f, input bit rm, output int r0, output int fl0,
                      output int r8, output int fl8, output int lat);
    @(negedge clk);
    b0.in_valid = 1'b1; b0.floatin = f; b0.round_mode = rm; b0.out_ready = 1'b1;
    b8.in_valid = 1'b1; b8.floatin = f; b8.round_mode = rm; b8.out_ready = 1'b1;
    @(negedge clk);
    b0.in_valid = 1'b0;
    b8.in_valid = 1'b0;
    lat = 1;
    while (!b0.out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    r0  = int'(b0.intout);
    fl0 = flags0();
    r8  = int'(b8.intout);
    fl8 = flags8();
  endtask

  logic [31:0] fv[10] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                          32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int r0, fl0, r8, fl8, lat;
    int sent, rcvd, cyc, held, seen;
    bit stalled;

    reset = 1'b0;
    b0.in_valid = 1'b0; b0.floatin = '0; b0.round_mode = 1'b0; b0.out_ready = 1'b1;
    b8.in_valid = 1'b0; b8.floatin = '0; b8.round_mode = 1'b0; b8.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_out_valid", int'(b0.out_valid), 0);
    check("rst_in_ready", int'(b0.in_ready), 0);
    check("rst_intout", int'(b0.intout), 0);
    check("rst_flags", flags0(), 0);
    reset = 1'b1;

    add(32'h3FC00000, 0, 1, 0, 384, 0);
    add(32'hC0700000, 0, -3, 0, -960, 0);
    add(32'h00000000, 0, 0, 0, 0, 0);
    add(32'h3FC00000, 1, 2, 0, 384, 0);
    add(32'h40200000, 1, 2, 0, 640, 0);
    add(32'hC0700000, 1, -4, 0, -960, 0);
    add(32'hBFC00000, 1, -2, 0, -384, 0);
    add(32'h3F000000, 1, 0, 1, 128, 0);
    add(32'h3F000000, 0, 0, 1, 128, 0);
    add(32'hBF000000, 1, 0, 1, -128, 0);
    add(32'h47800000, 1, 32767, 4, 32767, 4);
    add(32'hC7000000, 1, -32768, 0, -32768, 4);
    add(32'hC71C4000, 0, -32768, 4, -32768, 4);
    add(32'h7F800000, 0, 32767, 4, 32767, 4);
    add(32'hFF800000, 1, -32768, 4, -32768, 4);
    add(32'h7FC00000, 1, 0, 2, 0, 2);
    add(32'h7F7FFFFF, 0, 32767, 4, 32767, 4);
    add(32'hBFA00000, 1, -1, 0, -320, 0);
    add(32'h43480000, 1, 200, 0, 32767, 4);
    add(32'h80000000, 1, 0, 0, 0, 0);
    add(32'h00000001, 1, 0, 0, 0, 0);
    add(32'h3EFFFFFF, 1, 0, 1, 128, 0);
    add(32'h3EFFFFFF, 0, 0, 1, 127, 0);

    foreach (vt[i]) begin
      conv(vt[i].f, vt[i].rm, r0, fl0, r8, fl8, lat);
      check($sformatf("lat[%0d]", i), lat, 3);
      check($sformatf("f0_val[%0d]", i), r0, vt[i].e0);
      check($sformatf("f0_flg[%0d]", i), fl0, vt[i].fl0);
      check($sformatf("f8_val[%0d]", i), r8, vt[i].e8);
      check($sformatf("f8_flg[%0d]", i), fl8, vt[i].fl8);
    end

    // Streaming with out_ready pattern 1-0-0-1.
    sent = 0; rcvd = 0; cyc = 0; held = 0; stalled = 1'b0;
    while (rcvd < 10 && cyc < 100) begin
      @(negedge clk);
      b0.out_ready  = (cyc % 4 == 0) || (cyc % 4 == 3);
      b0.in_valid   = (sent < 10);
      b0.floatin    = (sent < 10) ? fv[sent] : 32'h0;
      b0.round_mode = 1'b0;
      #1;
      if (stalled) begin
        check("stall_valid", int'(b0.out_valid), 1);
        check("stall_hold", int'(b0.intout), held);
      end
      check("in_ready", int'(b0.in_ready), (b0.out_valid && !b0.out_ready) ? 0 : 1);
      if (b0.out_valid && b0.out_ready) begin
        check("stream_data", int'(b0.intout), rcvd + 1);
        rcvd++;
      end
      stalled = b0.out_valid && !b0.out_ready;
      held    = int'(b0.intout);
      if (b0.in_valid && b0.in_ready) sent++;
      cyc++;
    end
    b0.in_valid = 1'b0;
    b0.out_ready = 1'b1;
    check("stream_count", rcvd, 10);
    repeat (4) @(negedge clk);
    check("stream_no_dup", int'(b0.out_valid), 0);

    // Reset with two samples in flight.
    @(negedge clk);
    b0.in_valid = 1'b1; b0.floatin = 32'h3F800000;
    b8.in_valid = 1'b1; b8.floatin = 32'h3F800000;
    @(negedge clk);
    b0.floatin = 32'h40000000;
    b8.floatin = 32'h40000000;
    @(negedge clk);
    b0.in_valid = 1'b0;
    b8.in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_mid_in_ready", int'(b0.in_ready), 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_valid", int'(b0.out_valid), 0);
    check("rst_mid_flags", flags0(), 0);
    check("rst_mid_intout", int'(b0.intout), 0);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (b0.out_valid || b8.out_valid) seen++;
    end
    check("rst_dropped", seen, 0);
    conv(32'h40400000, 0, r0, fl0, r8, fl8, lat);
    check("post_rst_lat", lat, 3);
    check("post_rst_f0", r0, 3);
    check("post_rst_f8", r8, 768);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
